alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result/HI/LO width (>= 4).
REQ-002 SHALL have parameter MUL_DELAY, default 2, multiply latency in cycles (>= 1).
REQ-003 SHALL have port clock  in  1  sole clock, rising edge; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  request valid for func this cycle.
REQ-006 SHALL have port func  in  Alu_Func width  operation code (Mult, Multu, Div, Divu, Mthi, Mtlo, Mfhi, Mflo; others ignored).
REQ-007 SHALL have port data1  in  DATA_W  rs operand / dividend / move source.
REQ-008 SHALL have port data2  in  DATA_W  rt operand / divisor.
REQ-009 SHALL have port result  out  DATA_W  Mfhi/Mflo read data.
REQ-010 SHALL have port zero  out  1  result == 0.
REQ-011 SHALL have port busy  out  1  multiply/divide in flight.
REQ-012 SHALL have port stall  out  1  request cannot be accepted this cycle.

Function
REQ-013 SHALL hold internal HI and LO registers of DATA_W bits each.
REQ-014 SHALL run FSM states IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-015 SHALL assert stall = start & busy & func in {Mult, Multu, Div, Divu, Mthi, Mtlo, Mfhi, Mflo}; stalled requests ignored, no state change.
REQ-016 IDLE + start + Mult/Multu: latch operands, go MUL, load counter MUL_DELAY-1; when counter hits 0, write 2*DATA_W product {HI,LO}, return IDLE; busy high exactly MUL_DELAY cycles.
REQ-017 Mult SHALL treat operands as two's complement; Multu as unsigned; product never truncated.
REQ-018 IDLE + start + Div/Divu: latch operands, go DIV; radix-2 restoring, one quotient bit/cycle for DATA_W cycles, then FIX (one cycle), then IDLE; busy high DATA_W+1 cycles.
REQ-019 Div SHALL divide magnitudes; FIX negates quotient if operand signs differ, negates remainder if dividend negative (truncate toward zero); LO=quotient, HI=remainder.
REQ-020 Divisor 0 (Div or Divu) SHALL give LO = all ones, HI = data1, same latency.
REQ-021 Div with data1 = most-negative, data2 = -1 SHALL give LO = most-negative, HI = 0.
REQ-022 IDLE + start + Mthi/Mtlo SHALL write data1 to HI/LO at next edge; busy stays low.
REQ-023 Mfhi/Mflo not stalled SHALL drive result combinationally from HI/LO; otherwise result = 0.
REQ-024 Mthi/Mtlo in same cycle as a multiply/divide completion SHALL not occur (stalled); completion write has sole access.
REQ-025 Operand changes on data1/data2 after acceptance SHALL not affect an in-flight operation.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, counter 0, HI=0, LO=0, latched operands 0; busy=0, stall=0, result=0, zero=1.
REQ-027 Reset mid-operation SHALL abort; no HI/LO write after release; first edge after release may accept a new request.

Structure
REQ-028 Alu_Func codes SHALL come from the existing shared Alu func definitions; FSM state encoding and divide-by-zero constants SHALL live in the shared Alu package.
REQ-029 Iterative divider datapath (remainder/quotient shift, subtract, FIX sign correction) SHALL be sub-module alu_muldiv_divider; multiplier counter and HI/LO in top.
REQ-030 RTL SHALL be synthesizable, no latches, one always_ff for all state.

Verification (DATA_W=4, MUL_DELAY=2)
REQ-031 Multu 0xA*0xA -> busy 2 cycles, then Mfhi=0x6, Mflo=0x4.
REQ-032 Mult 0xD(-3)*0x5 -> HI=0xF, LO=0x1 (-15); Mthi 0xA then Mfhi -> 0xA, zero=0.
REQ-033 Div 0x7/0xE(-2) -> busy 5 cycles, LO=0xD(-3), HI=0x1; Divu 0x9/0x0 -> LO=0xF, HI=0x9.
REQ-034 Div 0x8/0xF -> LO=0x8, HI=0x0; Divu 0xF/0x3 -> LO=0x5, HI=0x0, Mfhi zero=1.
REQ-035 Mfhi/Mthi issued during divide -> stall=1, result=0, HI unchanged; after busy falls, Mfhi returns divide remainder.
REQ-036 reset_n low 2 cycles into Divu -> busy=0 immediately, HI=LO=0, no later write; new Multu 0x3*0x3 after release -> LO=0x9, HI=0x0.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: shared ALU function codes, mul/div FSM states and divide-by-zero constants
package alu_muldiv_pkg;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_SLT   = 4'h5,
    ALU_SLL   = 4'h6,
    ALU_SRL   = 4'h7,
    ALU_MULT  = 4'h8,
    ALU_MULTU = 4'h9,
    ALU_DIV   = 4'hA,
    ALU_DIVU  = 4'hB,
    ALU_MTHI  = 4'hC,
    ALU_MTLO  = 4'hD,
    ALU_MFHI  = 4'hE,
    ALU_MFLO  = 4'hF
  } alu_func_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} md_state_e;

  // Quotient fill bit on divide-by-zero; the remainder path naturally yields the dividend
  localparam logic DIV0_QUOT_BIT = 1'b1;

  function automatic logic is_muldiv(input alu_func_e f);
    return f[3];
  endfunction
endpackage

// File: rtl/alu_muldiv_divider.sv
// alu_muldiv_divider: radix-2 restoring divider on magnitudes with sign fix-up on the outputs
module alu_muldiv_divider
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_quo,
  output logic [DATA_W-1:0] o_rem
);
  logic [DATA_W-1:0] r_rem, r_quo, r_dsr, w_abs_a, w_abs_b;
  logic r_neg_q, r_neg_r, r_dvz, w_sa, w_sb;
  logic [DATA_W:0] w_shift, w_diff;
  assign w_sa    = i_signed & i_a[DATA_W-1];
  assign w_sb    = i_signed & i_b[DATA_W-1];
  assign w_abs_a = w_sa ? -i_a : i_a;
  assign w_abs_b = w_sb ? -i_b : i_b;
  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_dsr};
  // Zero divisor leaves |dividend| in the remainder, so only the quotient needs forcing
  assign o_quo = r_dvz ? {DATA_W{DIV0_QUOT_BIT}} : r_neg_q ? -r_quo : r_quo;
  assign o_rem = r_neg_r ? -r_rem : r_rem;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dsr   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dvz   <= 1'b0;
    end else if (i_load) begin
      r_rem   <= '0;
      r_quo   <= w_abs_a;
      r_dsr   <= w_abs_b;
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      r_dvz   <= i_b == '0;
    end else if (i_step) begin
      r_rem <= w_diff[DATA_W] ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
      r_quo <= {r_quo[DATA_W-2:0], ~w_diff[DATA_W]};
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: HI/LO multiply/divide unit with fixed-latency multiplier and iterative divider
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MUL_DELAY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  alu_func_e         func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              busy,
  output logic              stall
);
  localparam int CW = $clog2((MUL_DELAY > DATA_W ? MUL_DELAY : DATA_W) + 1);
  md_state_e r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_hi, r_lo, r_op1, r_op2, w_quo, w_rem;
  logic [2*DATA_W-1:0] w_ext1, w_ext2, w_prod;
  logic r_sgn, w_acc, w_mul, w_div, w_cnt0;
  assign busy   = r_state != ST_IDLE;
  assign stall  = start & busy & is_muldiv(func);
  assign w_acc  = start & ~busy;
  assign w_mul  = w_acc & (func == ALU_MULT || func == ALU_MULTU);
  assign w_div  = w_acc & (func == ALU_DIV || func == ALU_DIVU);
  assign w_cnt0 = r_cnt == '0;
  assign result = (w_acc && func == ALU_MFHI) ? r_hi : (w_acc && func == ALU_MFLO) ? r_lo : '0;
  assign zero   = result == '0;
  // Sign-extend to full width so one modular multiply serves both signed and unsigned
  assign w_ext1 = {{DATA_W{r_sgn & r_op1[DATA_W-1]}}, r_op1};
  assign w_ext2 = {{DATA_W{r_sgn & r_op2[DATA_W-1]}}, r_op2};
  assign w_prod = w_ext1 * w_ext2;
  alu_muldiv_divider #(.DATA_W(DATA_W)) u_div (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_div),
    .i_step  (r_state == ST_DIV),
    .i_signed(func == ALU_DIV),
    .i_a     (data1),
    .i_b     (data2),
    .o_quo   (w_quo),
    .o_rem   (w_rem)
  );
  always_comb begin
    w_next = r_state == ST_IDLE ? (w_mul ? ST_MUL : w_div ? ST_DIV : ST_IDLE)
           : r_state == ST_FIX ? ST_IDLE
           : w_cnt0 ? (r_state == ST_MUL ? ST_IDLE : ST_FIX) : r_state;
    w_cnt_nxt = w_mul ? CW'(MUL_DELAY - 1) : w_div ? CW'(DATA_W - 1)
              : (busy && !w_cnt0) ? r_cnt - CW'(1) : r_cnt;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_sgn   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_mul || w_div) begin
        r_op1 <= data1;
        r_op2 <= data2;
        r_sgn <= func == ALU_MULT || func == ALU_DIV;
      end
      if (r_state == ST_MUL && w_cnt0) {r_hi, r_lo} <= w_prod;
      else if (r_state == ST_FIX) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else if (w_acc && func == ALU_MTHI) r_hi <= data1;
      else if (w_acc && func == ALU_MTLO) r_lo <= data1;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized scoreboard bench for alu_muldiv against an arithmetic HI/LO model
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;
  localparam int W = 4;
  localparam int D = 2;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  alu_func_e func = ALU_ADD;
  logic [W-1:0] data1 = '0, data2 = '0, result;
  logic zero, busy, stall;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] exp_q[$];
  int checks = 0, errors = 0;
  alu_muldiv #(.DATA_W(W), .MUL_DELAY(D)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .func(func),
    .data1(data1), .data2(data2), .result(result), .zero(zero), .busy(busy), .stall(stall)
  );
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input alu_func_e f, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    longint p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (f)
      ALU_MULT:  begin p = longint'(sa) * longint'(sb); m_lo = W'(p); m_hi = W'(p >>> W); end
      ALU_MULTU: begin p = longint'(a) * longint'(b); m_lo = W'(p); m_hi = W'(p >>> W); end
      ALU_DIVU:  if (b == 0) begin m_lo = '1; m_hi = a; end else begin m_lo = a / b; m_hi = a % b; end
      ALU_DIV:   if (b == 0) begin m_lo = '1; m_hi = a; end else begin m_lo = W'(sa / sb); m_hi = W'(sa % sb); end
      ALU_MTHI:  m_hi = a;
      ALU_MTLO:  m_lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input alu_func_e f, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; func = f; data1 = a; data2 = b;
    if (f == ALU_MFHI) exp_q.push_back(m_hi);
    else if (f == ALU_MFLO) exp_q.push_back(m_lo);
    model(f, a, b);
    @(posedge clock); #1;
    start = 1'b0; data1 = W'($urandom); data2 = W'($urandom);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic run_op(input alu_func_e f, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    issue(f, a, b);
    wait_idle(n);
    check($sformatf("busy_cycles_%s", f.name()), n,
          (f == ALU_MULT || f == ALU_MULTU) ? D : (f == ALU_DIV || f == ALU_DIVU) ? W + 1 : 0);
  endtask

  task automatic read_both();
    run_op(ALU_MFHI, W'($urandom), W'($urandom));
    run_op(ALU_MFLO, W'($urandom), W'($urandom));
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clock);
      if (reset_n && start && (func == ALU_MFHI || func == ALU_MFLO)) begin
        if (stall) check("stalled_result", result, 0);
        else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got %0h expected no read", result);
        end else begin
          e = exp_q.pop_front();
          check("read_result", result, e);
          check("read_zero", zero, e == 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    alu_func_e wr_ops[7] = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO, ALU_ADD};
    int n;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    reset_n = 1'b1;
    @(posedge clock); #1;
    read_both();
    run_op(ALU_MULTU, 4'hA, 4'hA); read_both();
    run_op(ALU_MULT, 4'hD, 4'h5); read_both();
    run_op(ALU_MTHI, 4'hA, 4'h0); read_both();
    run_op(ALU_DIV, 4'h7, 4'hE); read_both();
    run_op(ALU_DIVU, 4'h9, 4'h0); read_both();
    run_op(ALU_DIV, 4'h8, 4'hF); read_both();
    run_op(ALU_DIVU, 4'hF, 4'h3); read_both();
    run_op(ALU_DIV, 4'hB, 4'h0); read_both();
    issue(ALU_DIV, 4'h7, 4'hE);
    start = 1'b1; func = ALU_MFHI; #1;
    check("stall_mfhi", stall, 1);
    check("stall_mfhi_result", result, 0);
    @(posedge clock); #1;
    func = ALU_MTHI; data1 = 4'h5; #1;
    check("stall_mthi", stall, 1);
    func = ALU_ADD; #1;
    check("no_stall_other", stall, 0);
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle(n);
    check("div_done", busy, 0);
    read_both();
    issue(ALU_DIVU, 4'h9, 4'h2);
    @(posedge clock); #1;
    reset_n = 1'b0; #1;
    check("abort_busy", busy, 0);
    check("abort_zero", zero, 1);
    m_hi = '0; m_lo = '0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (W + 3) @(posedge clock);
    #1;
    read_both();
    run_op(ALU_MULTU, 4'h3, 4'h3); read_both();
    for (int i = 0; i < 60; i++) begin
      run_op(wr_ops[$urandom_range(0, 6)], W'($urandom), W'($urandom));
      if (i % 3 == 0) read_both();
    end
    read_both();
    repeat (2) @(posedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
